// File: rtl/regfile_scoreboard.sv
// Parametrised GPR file with two combinational read ports, one write port and a
// per-register busy scoreboard (reserve at decode, release at writeback).
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic [AW:0]     busy_count
);

  localparam logic LP_BYP = (BYPASS != 0);
  localparam logic LP_ZR  = (ZERO_REG != 0);

  logic [XLEN-1:0] r_gpr [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_busy_count;

  logic w_wr_act;
  logic w_wr_ok;
  logic w_rsv_ok;
  logic w_inc;
  logic w_dec;

  // Qualified strobes and the per-edge count delta; a same-address reserve cancels the release
  always_comb begin
    w_wr_act = wr_en && !rst;
    w_wr_ok  = w_wr_act && !(LP_ZR && (wr_addr == '0));
    w_rsv_ok = rsv_en && !rst && !(LP_ZR && (rsv_addr == '0));
    w_inc    = w_rsv_ok && !r_busy[rsv_addr];
    w_dec    = w_wr_act && r_busy[wr_addr] && !(w_rsv_ok && (rsv_addr == wr_addr));
  end

  // Register array storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_gpr[wr_addr] <= wr_data;
    end
  end

  // Scoreboard: release first, then reserve, so a new producer wins on the same address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_wr_act) begin
        r_busy[wr_addr] <= 1'b0;
      end
      if (w_rsv_ok) begin
        r_busy[rsv_addr] <= 1'b1;
      end
      r_busy_count <= r_busy_count + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
    end
  end

  function automatic logic [XLEN-1:0] rd_data(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    if (LP_ZR && (a == '0)) begin
      v = '0;
    end else if (LP_BYP && w_wr_ok && (wr_addr == a)) begin
      v = wr_data;
    end else begin
      v = r_gpr[a];
    end
    return v;
  endfunction

  // A register being written back this cycle is no longer waiting on its producer
  function automatic logic rd_busy(input logic [AW-1:0] a);
    logic v;
    if (LP_ZR && (a == '0)) begin
      v = 1'b0;
    end else if (LP_BYP && w_wr_act && (wr_addr == a)) begin
      v = 1'b0;
    end else begin
      v = r_busy[a];
    end
    return v;
  endfunction

  assign rs1_data   = rd_data(rs1_addr);
  assign rs2_data   = rd_data(rs2_addr);
  assign rs1_busy   = rd_busy(rs1_addr);
  assign rs2_busy   = rd_busy(rs2_addr);
  assign busy_count = r_busy_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed table, corner sequences and random traffic
// against an array-based reference model, on a BYPASS/ZERO_REG instance and a plain one.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, rsv_addr;
  logic        wr_en, rsv_en;
  logic [31:0] wr_data;

  logic [31:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
  logic        a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy;
  logic [5:0]  a_count, b_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: index 0 = BYPASS=1/ZERO_REG=1 instance, 1 = BYPASS=0/ZERO_REG=0
  logic [31:0] m_gpr  [2][32];
  bit          m_busy [2][32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1d;
    logic        e1b;
    logic [31:0] e2d;
    logic        e2b;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  regfile_scoreboard u_dut_a (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
    .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_count(a_count)
  );

  regfile_scoreboard #(.BYPASS(0), .ZERO_REG(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_count(b_count)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_data(input int k, input logic [4:0] a);
    bit zr = (k == 0);
    bit bp = (k == 0);
    if (rst) return 32'd0;
    if (zr && a == 5'd0) return 32'd0;
    if (bp && wr_en && wr_addr == a) return wr_data;
    return m_gpr[k][a];
  endfunction

  function automatic logic m_bsy(input int k, input logic [4:0] a);
    bit zr = (k == 0);
    bit bp = (k == 0);
    if (rst) return 1'b0;
    if (zr && a == 5'd0) return 1'b0;
    if (bp && wr_en && wr_addr == a) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic logic [31:0] m_count(input int k);
    int c = 0;
    for (int i = 0; i < 32; i++) c += m_busy[k][i] ? 1 : 0;
    return 32'(c);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        m_gpr[k][i]  = 32'd0;
        m_busy[k][i] = 1'b0;
      end
  endtask

  task automatic model_update();
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        bit zr = (k == 0);
        if (wr_en && !(zr && wr_addr == 5'd0)) m_gpr[k][wr_addr] = wr_data;
        if (wr_en) m_busy[k][wr_addr] = 1'b0;
        if (rsv_en && !(zr && rsv_addr == 5'd0)) m_busy[k][rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    cmp("A rs1_data", a_rs1_data, m_data(0, rs1_addr));
    cmp("A rs2_data", a_rs2_data, m_data(0, rs2_addr));
    cmp("A rs1_busy", {31'd0, a_rs1_busy}, {31'd0, m_bsy(0, rs1_addr)});
    cmp("A rs2_busy", {31'd0, a_rs2_busy}, {31'd0, m_bsy(0, rs2_addr)});
    cmp("A busy_count", {26'd0, a_count}, m_count(0));
    cmp("B rs1_data", b_rs1_data, m_data(1, rs1_addr));
    cmp("B rs2_data", b_rs2_data, m_data(1, rs2_addr));
    cmp("B rs1_busy", {31'd0, b_rs1_busy}, {31'd0, m_bsy(1, rs1_addr)});
    cmp("B rs2_busy", {31'd0, b_rs2_busy}, {31'd0, m_bsy(1, rs2_addr)});
    cmp("B busy_count", {26'd0, b_count}, m_count(1));
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra,
                       input logic [4:0] r1, input logic [4:0] r2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra;
    rs1_addr = r1; rs2_addr = r2;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra,
                       input logic [4:0] r1, input logic [4:0] r2);
    drive(we, wa, wd, re, ra, r1, r2);
    #2;
    check_all();
    finish_cycle();
  endtask

  initial begin
    // Directed sequence; expectations are for the BYPASS=1/ZERO_REG=1 instance
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 6'd0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd6, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 6'd0};
    tbl[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 6'd0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 6'd0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd7, 32'h0,        1'b0, 32'h0,        1'b0, 6'd0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd3, 5'd7, 32'h0,        1'b1, 32'h0,        1'b0, 6'd1};
    tbl[6]  = '{1'b1, 5'd7, 32'h000000A5, 1'b0, 5'd0, 5'd3, 5'd7, 32'h0,        1'b1, 32'h000000A5, 1'b0, 6'd2};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd3, 32'h000000A5, 1'b0, 32'h0,        1'b1, 6'd1};
    tbl[8]  = '{1'b1, 5'd9, 32'h00000055, 1'b1, 5'd9, 5'd9, 5'd3, 32'h00000055, 1'b0, 32'h0,        1'b1, 6'd1};
    tbl[9]  = '{1'b1, 5'd3, 32'h00000033, 1'b1, 5'd4, 5'd9, 5'd4, 32'h00000055, 1'b1, 32'h0,        1'b0, 6'd2};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd4, 32'h00000033, 1'b0, 32'h0,        1'b1, 6'd2};

    rst = 1'b1;
    m_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd5);
    #12;
    check_all();
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int a = 0; a < 32; a++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(a), 5'(31 - a));

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].r1, tbl[i].r2);
      #2;
      cmp($sformatf("tbl%0d rs1_data", i), a_rs1_data, tbl[i].e1d);
      cmp($sformatf("tbl%0d rs1_busy", i), {31'd0, a_rs1_busy}, {31'd0, tbl[i].e1b});
      cmp($sformatf("tbl%0d rs2_data", i), a_rs2_data, tbl[i].e2d);
      cmp($sformatf("tbl%0d rs2_busy", i), {31'd0, a_rs2_busy}, {31'd0, tbl[i].e2b});
      cmp($sformatf("tbl%0d busy_count", i), {26'd0, a_count}, {26'd0, tbl[i].ecnt});
      check_all();
      finish_cycle();
    end

    // Fill the scoreboard, re-reserve, then drain it
    for (int a = 1; a < 32; a++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 5'(a), 5'd1);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd1, 5'd31);
    #2;
    cmp("full count", {26'd0, a_count}, 32'd31);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd31);
    for (int a = 0; a < 32; a++) cycle(1'b1, 5'(a), 32'(a * 3 + 1), 1'b0, 5'd0, 5'(a), 5'd31);
    #2;
    cmp("drained count", {26'd0, a_count}, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd9);

    // Async reset pulsed between edges after some writes and reservations
    cycle(1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 5'd7, 5'd5, 5'd7);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd5, 5'd7);
    drive(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd6, 5'd5, 5'd7);
    rst = 1'b1;
    #1;
    m_reset();
    check_all();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd8);
    #1;
    check_all();
    finish_cycle();

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, ra, r1, r2;
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ra, r1, r2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
